button_io_responder: RTL and testbench

Memory-mapped responder for the front-panel buttons (start, left, right, all active-low pins). It synchronizes and debounces each pin, latches press events into sticky pending bits, and answers CPU loads from the button address with a 16-bit button code on the cycle after the address is presented. This matches the one-cycle-delayed read path into the CPU's register-write and instruction muxes. It replaces the raw, undebounced pin sampling on the load path.

---
 rtl/button_io_responder.sv | 140 ++++++++++++++
 tb/tb_button_io_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_io_responder.sv
// ============================================================================
// button_io_responder: debounced front-panel buttons with a one-cycle-latency
// memory-mapped read port and sticky press-event bits.  Rev 1.0
// ============================================================================
`default_nettype none

module button_io_responder #(
  parameter int                 WIDTH           = 16,
  parameter logic [WIDTH-1:0]   BUTTON_ADDR     = 16'hFFFF,
  parameter int                 DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             left,
  input  logic             right,
  input  logic [WIDTH-1:0] mem_address,
  input  logic             loading,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic [2:0]       held,
  output logic [2:0]       pending
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic [2:0] pins;
  logic [2:0] press_event;
  logic       hit;
  logic [2:0] src;
  logic [1:0] code;
  logic [2:0] clr_mask;

  assign pins = {right, left, start};
  assign hit  = loading && (mem_address == BUTTON_ADDR);

  for (genvar i = 0; i < 3; i++) begin : g_pin
    logic [1:0]       sync_ff;
    db_state_t        state;
    logic [CNT_W-1:0] count;
    logic             sync;

    assign sync = sync_ff[1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_ff <= 2'b11;
        state   <= RELEASED;
        count   <= '0;
      end else begin
        sync_ff <= {sync_ff[0], pins[i]};
        case (state)
          RELEASED: begin
            if (!sync) begin
              state <= PRESS_WAIT;
              count <= CNT_W'(1);
            end
          end
          PRESS_WAIT: begin
            if (sync) begin
              state <= RELEASED;
              count <= '0;
            end else if (count == CNT_MAX) begin
              state <= PRESSED;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (sync) begin
              state <= RELEASE_WAIT;
              count <= CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            if (!sync) begin
              state <= PRESSED;
              count <= '0;
            end else if (count == CNT_MAX) begin
              state <= RELEASED;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          default: begin
            state <= RELEASED;
            count <= '0;
          end
        endcase
      end
    end

    assign held[i]        = (state == PRESSED) || (state == RELEASE_WAIT);
    assign press_event[i] = (state == PRESS_WAIT) && !sync && (count == CNT_MAX);
  end

  // Lowest-numbered button wins; only the reported button's pending bit clears.
  assign src = pending | held;

  always_comb begin
    code     = 2'd0;
    clr_mask = 3'b000;
    if (src[0]) begin
      code     = 2'd1;
      clr_mask = 3'b001;
    end else if (src[1]) begin
      code     = 2'd2;
      clr_mask = 3'b010;
    end else if (src[2]) begin
      code     = 2'd3;
      clr_mask = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      pending    <= 3'b000;
    end else begin
      read_data  <= hit ? WIDTH'(code) : '0;
      read_valid <= hit;
      // A new event on the same edge as a clear keeps the bit set.
      pending    <= (pending & ~(hit ? clr_mask : 3'b000)) | press_event;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_io_responder.sv
// ============================================================================
// tb_button_io_responder: table vectors, hand sequences and random stimulus
// against a run-length debounce reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_button_io_responder;

  localparam int          DB   = 4;
  localparam logic [15:0] ADDR = 16'hFFFF;
  localparam logic [2:0]  REL  = 3'b111;
  localparam logic [2:0]  PS   = 3'b110;
  localparam logic [2:0]  PL   = 3'b101;
  localparam logic [2:0]  PR   = 3'b011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b1, left = 1'b1, right = 1'b1;
  logic [15:0] mem_address = 16'h0000;
  logic        loading = 1'b0;
  logic [15:0] read_data;
  logic        read_valid;
  logic [2:0]  held, pending;

  int vectors = 0;
  int miscompares = 0;

  button_io_responder #(
    .WIDTH(16), .BUTTON_ADDR(ADDR), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .mem_address(mem_address), .loading(loading),
    .read_data(read_data), .read_valid(read_valid),
    .held(held), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got time=%0t required < 2000000", $time);
    $fatal(1, "timeout");
  end

  // Reference model: pin level seen after two stages, count of consecutive
  // samples disagreeing with the accepted level; DB of them flips the level.
  bit       s1[3], s2[3];
  int       run[3];
  bit [2:0] mheld, mpend;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      s1[i] = 1'b1; s2[i] = 1'b1; run[i] = 0;
    end
    mheld = 3'b000;
    mpend = 3'b000;
  endfunction

  task automatic check(input string name, input logic [15:0] ed, input logic ev,
                       input logic [2:0] eh, input logic [2:0] ep);
    vectors++;
    if (read_data !== ed || read_valid !== ev || held !== eh || pending !== ep) begin
      miscompares++;
      $display("FAIL %s @%0t: got data=%h valid=%b held=%b pending=%b, required data=%h valid=%b held=%b pending=%b",
               name, $time, read_data, read_valid, held, pending, ed, ev, eh, ep);
    end
  endtask

  task automatic step(input logic [2:0] p, input logic ld, input logic [15:0] a);
    logic [2:0]  src, clr, ev;
    logic [15:0] code;
    logic        hit;
    {right, left, start} = p;
    loading     = ld;
    mem_address = a;
    @(posedge clk);
    #1;
    hit  = ld && (a == ADDR);
    src  = mpend | mheld;
    code = 16'd0;
    clr  = 3'b000;
    if (src[0])      begin code = 16'd1; clr = 3'b001; end
    else if (src[1]) begin code = 16'd2; clr = 3'b010; end
    else if (src[2]) begin code = 16'd3; clr = 3'b100; end
    ev = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if ((!s2[i]) != mheld[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          mheld[i] = ~mheld[i];
          run[i]   = 0;
          if (mheld[i]) ev[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
      s2[i] = s1[i];
      s1[i] = p[i];
    end
    mpend = (mpend & ~(hit ? clr : 3'b000)) | ev;
    check("model", hit ? code : 16'd0, hit, mheld, mpend);
  endtask

  task automatic async_reset();
    #3 reset = 1'b0;
    #1 check("reset_async", 16'd0, 1'b0, 3'b000, 3'b000);
    model_reset();
    {right, left, start} = REL;
    loading = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  pins;
    logic        ld;
    logic [15:0] addr;
    int          cycles;
    logic [15:0] data;
    logic        valid;
    logic [2:0]  hld;
    logic [2:0]  pnd;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic [2:0] p, input logic ld, input logic [15:0] a,
                              input int n, input logic [15:0] d, input logic v,
                              input logic [2:0] h, input logic [2:0] pn);
    row_t r;
    r.pins = p; r.ld = ld; r.addr = a; r.cycles = n;
    r.data = d; r.valid = v; r.hld = h; r.pnd = pn;
    tbl.push_back(r);
  endfunction

  initial begin
    int dur[3];
    logic [2:0] lvl;

    // clean press of left, read at edge 10
    add(PL,  0, 16'h0000, 5, 16'h0, 0, 3'b000, 3'b000);
    add(PL,  0, 16'h0000, 1, 16'h0, 0, 3'b010, 3'b010);
    add(PL,  0, 16'h0000, 3, 16'h0, 0, 3'b010, 3'b010);
    add(PL,  1, ADDR,     1, 16'h2, 1, 3'b010, 3'b000);
    add(PL,  0, 16'h0000, 1, 16'h0, 0, 3'b010, 3'b000);
    add(REL, 0, 16'h0000, 5, 16'h0, 0, 3'b010, 3'b000);
    add(REL, 0, 16'h0000, 1, 16'h0, 0, 3'b000, 3'b000);
    // right glitch of three samples
    add(PR,  0, 16'h0000, 3, 16'h0, 0, 3'b000, 3'b000);
    add(REL, 0, 16'h0000, 6, 16'h0, 0, 3'b000, 3'b000);
    add(REL, 1, ADDR,     1, 16'h0, 1, 3'b000, 3'b000);
    // priority and partial clear, with non-hit accesses in between
    add(PL,  0, 16'h0000, 6, 16'h0, 0, 3'b010, 3'b010);
    add(REL, 0, 16'h0000, 6, 16'h0, 0, 3'b000, 3'b010);
    add(PS,  0, 16'h0000, 6, 16'h0, 0, 3'b001, 3'b011);
    add(REL, 0, 16'h0000, 6, 16'h0, 0, 3'b000, 3'b011);
    add(REL, 0, ADDR,     1, 16'h0, 0, 3'b000, 3'b011);
    add(REL, 1, 16'hFFFE, 1, 16'h0, 0, 3'b000, 3'b011);
    add(REL, 1, ADDR,     1, 16'h1, 1, 3'b000, 3'b010);
    add(REL, 1, ADDR,     1, 16'h2, 1, 3'b000, 3'b000);
    add(REL, 1, ADDR,     1, 16'h0, 1, 3'b000, 3'b000);
    // set and clear of pending[2] on the same edge
    add(PR,  0, 16'h0000, 6, 16'h0, 0, 3'b100, 3'b100);
    add(REL, 0, 16'h0000, 6, 16'h0, 0, 3'b000, 3'b100);
    add(PR,  0, 16'h0000, 5, 16'h0, 0, 3'b000, 3'b100);
    add(PR,  1, ADDR,     1, 16'h3, 1, 3'b100, 3'b100);
    add(PR,  1, ADDR,     1, 16'h3, 1, 3'b100, 3'b000);
    add(REL, 0, 16'h0000, 6, 16'h0, 0, 3'b000, 3'b000);

    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", 16'd0, 1'b0, 3'b000, 3'b000);
    reset = 1'b1;

    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].cycles; c++) step(tbl[k].pins, tbl[k].ld, tbl[k].addr);
      check($sformatf("row%0d", k), tbl[k].data, tbl[k].valid, tbl[k].hld, tbl[k].pnd);
    end

    // reset in the middle of activity with non-zero outputs
    repeat (6) step(PL, 0, 16'h0000);
    repeat (6) step(3'b100, 0, 16'h0000);
    step(3'b100, 1, ADDR);
    check("pre_reset", 16'h1, 1'b1, 3'b011, 3'b010);
    async_reset();
    repeat (3) step(REL, 0, 16'h0000);
    step(REL, 1, ADDR);
    check("post_reset_hit", 16'h0, 1'b1, 3'b000, 3'b000);

    // randomized pins and bus traffic, model-checked every cycle
    lvl = REL;
    for (int i = 0; i < 3; i++) dur[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = $urandom_range(1, 10);
        end
        dur[i]--;
      end
      if ($urandom_range(0, 999) == 0) async_reset();
      step(lvl, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 16'($urandom) : ADDR);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
